mpt_walk_arbiter: RTL and testbench

Shares a single memory-protection-table walker (`mtt_top`) between `NUM_REQ` requesters, e.g. instruction fetch and load/store. It accepts one lookup at a time with round-robin priority and drives the walker's enable/address/access-type inputs for the granted lookup. It waits for the walker's result, with a timeout, and returns the registered result to the owning requester. It sits between the core-side permission checkers and the walker, and also carries the walker flush.

---
 rtl/mpt_walk_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mpt_walk_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpt_walk_arbiter.sv
// +-----------------------------------------------------------------------------+
// | mpt_walk_arbiter: round-robin arbiter sharing one MPT walker among NUM_REQ  |
// | requesters, with a WAIT timeout and a flush pass-through. Revision 1.0      |
// +-----------------------------------------------------------------------------+
`default_nettype none

module mpt_walk_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int PLEN           = 34,
  parameter int TLB_ENTRY_LEN  = 64,
  parameter int ACCESS_W       = 2,
  parameter int FORMAT_W       = 3
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic                               flush_i,
  input  logic [NUM_REQ-1:0]                 req_valid_i,
  output logic [NUM_REQ-1:0]                 req_ready_o,
  input  logic [NUM_REQ-1:0][PLEN-1:0]       req_paddr_i,
  input  logic [NUM_REQ-1:0][ACCESS_W-1:0]   req_access_i,
  output logic [NUM_REQ-1:0]                 rsp_valid_o,
  output logic                               rsp_allow_o,
  output logic                               rsp_fault_o,
  output logic                               rsp_timeout_o,
  output logic [FORMAT_W-1:0]                rsp_format_o,
  output logic [TLB_ENTRY_LEN-1:0]           rsp_tlb_entry_o,
  output logic                               ptw_enable_o,
  output logic                               addr_valid_o,
  output logic [PLEN-1:0]                    paddr_o,
  output logic [ACCESS_W-1:0]                access_type_o,
  output logic                               flush_o,
  input  logic                               ptw_busy_i,
  input  logic                               ptw_valid_i,
  input  logic                               access_page_fault_i,
  input  logic [FORMAT_W-1:0]                format_error_i,
  input  logic                               allow_i,
  input  logic [TLB_ENTRY_LEN-1:0]           tlb_entry_i
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_e;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]         owner_q, owner_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [PLEN-1:0]          paddr_q, paddr_d;
  logic [ACCESS_W-1:0]      access_q, access_d;
  logic                     ptw_en_q, ptw_en_d;
  logic                     addr_valid_q, addr_valid_d;
  logic [NUM_REQ-1:0]       rsp_valid_q, rsp_valid_d;
  logic                     rsp_allow_q, rsp_allow_d;
  logic                     rsp_fault_q, rsp_fault_d;
  logic                     rsp_timeout_q, rsp_timeout_d;
  logic [FORMAT_W-1:0]      rsp_format_q, rsp_format_d;
  logic [TLB_ENTRY_LEN-1:0] rsp_tlb_q, rsp_tlb_d;

  logic                     gnt_found;
  logic [PTR_W-1:0]         gnt_idx;
  logic                     walk_done;
  logic                     unused_busy;

  // Busy is informational only; completion is judged from the result strobes.
  assign unused_busy = ptw_busy_i;
  assign walk_done   = ptw_valid_i | access_page_fault_i | (format_error_i != '0);

  always_comb begin
    logic [PTR_W-1:0] cand;
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = rr_ptr_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt_found && req_valid_i[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
      cand = (cand == PTR_LAST) ? '0 : cand + 1'b1;
    end
  end

  assign req_ready_o = (rst_ni && !flush_i && state_q == S_IDLE && gnt_found)
                       ? (NUM_REQ'(1) << gnt_idx) : '0;

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    owner_d       = owner_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    access_d      = access_q;
    rsp_allow_d   = rsp_allow_q;
    rsp_fault_d   = rsp_fault_q;
    rsp_timeout_d = rsp_timeout_q;
    rsp_format_d  = rsp_format_q;
    rsp_tlb_d     = rsp_tlb_q;

    if (flush_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (gnt_found) begin
            owner_d  = gnt_idx;
            paddr_d  = req_paddr_i[gnt_idx];
            access_d = req_access_i[gnt_idx];
            rr_ptr_d = (gnt_idx == PTR_LAST) ? '0 : gnt_idx + 1'b1;
            state_d  = S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // A real completion takes precedence over an expiring counter.
          if (walk_done) begin
            rsp_allow_d   = allow_i;
            rsp_fault_d   = access_page_fault_i;
            rsp_timeout_d = 1'b0;
            rsp_format_d  = format_error_i;
            rsp_tlb_d     = tlb_entry_i;
            state_d       = S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            rsp_allow_d   = 1'b0;
            rsp_fault_d   = 1'b1;
            rsp_timeout_d = 1'b1;
            rsp_format_d  = '0;
            rsp_tlb_d     = '0;
            state_d       = S_RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_RESP:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    ptw_en_d     = (state_d == S_ISSUE) || (state_d == S_WAIT);
    addr_valid_d = (state_d == S_ISSUE);
    rsp_valid_d  = (state_d == S_RESP) ? (NUM_REQ'(1) << owner_d) : '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= '0;
      owner_q       <= '0;
      cnt_q         <= '0;
      paddr_q       <= '0;
      access_q      <= '0;
      ptw_en_q      <= 1'b0;
      addr_valid_q  <= 1'b0;
      rsp_valid_q   <= '0;
      rsp_allow_q   <= 1'b0;
      rsp_fault_q   <= 1'b0;
      rsp_timeout_q <= 1'b0;
      rsp_format_q  <= '0;
      rsp_tlb_q     <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      owner_q       <= owner_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      access_q      <= access_d;
      ptw_en_q      <= ptw_en_d;
      addr_valid_q  <= addr_valid_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_allow_q   <= rsp_allow_d;
      rsp_fault_q   <= rsp_fault_d;
      rsp_timeout_q <= rsp_timeout_d;
      rsp_format_q  <= rsp_format_d;
      rsp_tlb_q     <= rsp_tlb_d;
    end
  end

  assign rsp_valid_o     = rsp_valid_q;
  assign rsp_allow_o     = rsp_allow_q;
  assign rsp_fault_o     = rsp_fault_q;
  assign rsp_timeout_o   = rsp_timeout_q;
  assign rsp_format_o    = rsp_format_q;
  assign rsp_tlb_entry_o = rsp_tlb_q;
  assign ptw_enable_o    = ptw_en_q;
  assign addr_valid_o    = addr_valid_q;
  assign paddr_o         = paddr_q;
  assign access_type_o   = access_q;
  assign flush_o         = flush_i;

endmodule

`default_nettype wire

// File: tb/tb_mpt_walk_arbiter.sv
// +-----------------------------------------------------------------------------+
// | tb_mpt_walk_arbiter: cycle-vector bench for mpt_walk_arbiter (2 requesters, |
// | 4-cycle timeout). Revision 1.0                                              |
// +-----------------------------------------------------------------------------+
`default_nettype none

module tb_mpt_walk_arbiter;

  logic              clk_i;
  logic              rst_ni;
  logic              flush_i;
  logic [1:0]        req_valid_i;
  logic [1:0]        req_ready_o;
  logic [1:0][33:0]  req_paddr_i;
  logic [1:0][1:0]   req_access_i;
  logic [1:0]        rsp_valid_o;
  logic              rsp_allow_o;
  logic              rsp_fault_o;
  logic              rsp_timeout_o;
  logic [2:0]        rsp_format_o;
  logic [63:0]       rsp_tlb_entry_o;
  logic              ptw_enable_o;
  logic              addr_valid_o;
  logic [33:0]       paddr_o;
  logic [1:0]        access_type_o;
  logic              flush_o;
  logic              ptw_busy_i;
  logic              ptw_valid_i;
  logic              access_page_fault_i;
  logic [2:0]        format_error_i;
  logic              allow_i;
  logic [63:0]       tlb_entry_i;

  mpt_walk_arbiter #(
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i               (clk_i),
    .rst_ni              (rst_ni),
    .flush_i             (flush_i),
    .req_valid_i         (req_valid_i),
    .req_ready_o         (req_ready_o),
    .req_paddr_i         (req_paddr_i),
    .req_access_i        (req_access_i),
    .rsp_valid_o         (rsp_valid_o),
    .rsp_allow_o         (rsp_allow_o),
    .rsp_fault_o         (rsp_fault_o),
    .rsp_timeout_o       (rsp_timeout_o),
    .rsp_format_o        (rsp_format_o),
    .rsp_tlb_entry_o     (rsp_tlb_entry_o),
    .ptw_enable_o        (ptw_enable_o),
    .addr_valid_o        (addr_valid_o),
    .paddr_o             (paddr_o),
    .access_type_o       (access_type_o),
    .flush_o             (flush_o),
    .ptw_busy_i          (ptw_busy_i),
    .ptw_valid_i         (ptw_valid_i),
    .access_page_fault_i (access_page_fault_i),
    .format_error_i      (format_error_i),
    .allow_i             (allow_i),
    .tlb_entry_i         (tlb_entry_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    logic        fl;
    logic [1:0]  rv;
    logic        pv;
    logic        apf;
    logic [2:0]  fmt;
    logic        alw;
    logic [63:0] tlb;
    logic [1:0]  e_rdy;
    logic        e_en;
    logic        e_av;
    logic [1:0]  e_rsv;
    int          e_own;
    logic        e_chk;
    logic        e_alw;
    logic        e_flt;
    logic        e_to;
    logic [2:0]  e_fmt;
    logic [63:0] e_tlb;
  } vec_t;

  vec_t        vecs [64];
  int          nvec;
  int          checks;
  int          errors;
  logic [33:0] pa  [2];
  logic [1:0]  acc [2];

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: actual %0h required %0h", nm, $time, act, exp);
    end
  endtask

  task automatic add(input logic fl, input logic [1:0] rv, input logic pv, input logic apf,
                     input logic [2:0] fmt, input logic alw, input logic [63:0] tlb,
                     input logic [1:0] rdy, input logic en, input logic av,
                     input logic [1:0] rsv, input int own);
    vecs[nvec].fl    = fl;
    vecs[nvec].rv    = rv;
    vecs[nvec].pv    = pv;
    vecs[nvec].apf   = apf;
    vecs[nvec].fmt   = fmt;
    vecs[nvec].alw   = alw;
    vecs[nvec].tlb   = tlb;
    vecs[nvec].e_rdy = rdy;
    vecs[nvec].e_en  = en;
    vecs[nvec].e_av  = av;
    vecs[nvec].e_rsv = rsv;
    vecs[nvec].e_own = own;
    vecs[nvec].e_chk = 1'b0;
    vecs[nvec].e_alw = 1'b0;
    vecs[nvec].e_flt = 1'b0;
    vecs[nvec].e_to  = 1'b0;
    vecs[nvec].e_fmt = '0;
    vecs[nvec].e_tlb = '0;
    nvec++;
  endtask

  // Attach expected response data to the most recently added cycle.
  task automatic dat(input logic alw, input logic flt, input logic to,
                     input logic [2:0] fmt, input logic [63:0] tlb);
    vecs[nvec-1].e_chk = 1'b1;
    vecs[nvec-1].e_alw = alw;
    vecs[nvec-1].e_flt = flt;
    vecs[nvec-1].e_to  = to;
    vecs[nvec-1].e_fmt = fmt;
    vecs[nvec-1].e_tlb = tlb;
  endtask

  task automatic check_reset_outputs(input string tag);
    cmp({tag, "_req_ready"}, 64'(req_ready_o), 64'h0);
    cmp({tag, "_rsp_valid"}, 64'(rsp_valid_o), 64'h0);
    cmp({tag, "_rsp_allow"}, 64'(rsp_allow_o), 64'h0);
    cmp({tag, "_rsp_fault"}, 64'(rsp_fault_o), 64'h0);
    cmp({tag, "_rsp_timeout"}, 64'(rsp_timeout_o), 64'h0);
    cmp({tag, "_rsp_format"}, 64'(rsp_format_o), 64'h0);
    cmp({tag, "_rsp_tlb"}, rsp_tlb_entry_o, 64'h0);
    cmp({tag, "_ptw_enable"}, 64'(ptw_enable_o), 64'h0);
    cmp({tag, "_addr_valid"}, 64'(addr_valid_o), 64'h0);
    cmp({tag, "_paddr"}, 64'(paddr_o), 64'h0);
    cmp({tag, "_access"}, 64'(access_type_o), 64'h0);
    cmp({tag, "_flush_o"}, 64'(flush_o), 64'h0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nvec   = 0;
    pa[0]  = 34'h0_8000_1000;
    pa[1]  = 34'h0_8000_2000;
    acc[0] = 2'd0;
    acc[1] = 2'd1;

    // Single lookup from requester 0, walker answers at T+2.
    add(0, 2'b01, 0, 0, 0, 0, 64'h0,  2'b01, 0, 0, 2'b00, 0);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 1, 1, 2'b00, 0);
    add(0, 2'b00, 1, 0, 0, 1, 64'h5A, 2'b00, 1, 0, 2'b00, 0);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 0, 0, 2'b01, 0);
    dat(1, 0, 0, 0, 64'h5A);

    // Both requesters held valid: pointer sits at 1, so grants go 1,0,1,0.
    for (int k = 0; k < 4; k++) begin
      int         g;
      logic [1:0] oh;
      g  = (k % 2 == 0) ? 1 : 0;
      oh = (g == 1) ? 2'b10 : 2'b01;
      add(0, 2'b11, 0, 0, 0, 0, 64'h0, oh,    0, 0, 2'b00, g);
      add(0, 2'b11, 0, 0, 0, 0, 64'h0, 2'b00, 1, 1, 2'b00, g);
      add(0, 2'b11, 1, 0, 0, 1, 64'h10 + 64'(k), 2'b00, 1, 0, 2'b00, g);
      add(0, 2'b11, 0, 0, 0, 0, 64'h0, 2'b00, 0, 0, oh, g);
      dat(1, 0, 0, 0, 64'h10 + 64'(k));
    end

    // Requester 1: strobe during ISSUE is ignored, access fault one cycle late.
    add(0, 2'b10, 0, 0, 0, 0, 64'h0,  2'b10, 0, 0, 2'b00, 1);
    add(0, 2'b00, 1, 0, 0, 1, 64'hEE, 2'b00, 1, 1, 2'b00, 1);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 1, 0, 2'b00, 1);
    add(0, 2'b00, 0, 1, 0, 0, 64'h77, 2'b00, 1, 0, 2'b00, 1);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 0, 0, 2'b10, 1);
    dat(0, 1, 0, 0, 64'h77);

    // Requester 0: format error code carried through.
    add(0, 2'b01, 0, 0, 0, 0, 64'h0,  2'b01, 0, 0, 2'b00, 0);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 1, 1, 2'b00, 0);
    add(0, 2'b00, 0, 0, 3, 0, 64'h31, 2'b00, 1, 0, 2'b00, 0);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 0, 0, 2'b01, 0);
    dat(0, 0, 0, 3, 64'h31);

    // Requester 1: silent walker, forced response at T+6.
    add(0, 2'b10, 0, 0, 0, 0, 64'h0, 2'b10, 0, 0, 2'b00, 1);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0, 2'b00, 1, 1, 2'b00, 1);
    for (int k = 0; k < 4; k++)
      add(0, 2'b00, 0, 0, 0, 0, 64'h0, 2'b00, 1, 0, 2'b00, 1);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0, 2'b00, 0, 0, 2'b10, 1);
    dat(0, 1, 1, 0, 64'h0);

    // Flush in WAIT, flush held in IDLE, then requester 1 wins; its completion
    // lands on the last counter value and must beat the timeout.
    add(0, 2'b11, 0, 0, 0, 0, 64'h0,  2'b01, 0, 0, 2'b00, 0);
    add(0, 2'b10, 0, 0, 0, 0, 64'h0,  2'b00, 1, 1, 2'b00, 0);
    add(1, 2'b10, 0, 0, 0, 0, 64'h0,  2'b00, 1, 0, 2'b00, 0);
    add(1, 2'b10, 0, 0, 0, 0, 64'h0,  2'b00, 0, 0, 2'b00, 0);
    add(0, 2'b10, 0, 0, 0, 0, 64'h0,  2'b10, 0, 0, 2'b00, 1);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 1, 1, 2'b00, 1);
    for (int k = 0; k < 3; k++)
      add(0, 2'b00, 0, 0, 0, 0, 64'h0, 2'b00, 1, 0, 2'b00, 1);
    add(0, 2'b00, 1, 0, 0, 1, 64'h99, 2'b00, 1, 0, 2'b00, 1);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 0, 0, 2'b10, 1);
    dat(1, 0, 0, 0, 64'h99);
    add(0, 2'b00, 0, 0, 0, 0, 64'h0,  2'b00, 0, 0, 2'b00, 0);
    dat(1, 0, 0, 0, 64'h99);

    rst_ni              = 1'b0;
    flush_i             = 1'b0;
    req_valid_i         = '0;
    req_paddr_i[0]      = pa[0];
    req_paddr_i[1]      = pa[1];
    req_access_i[0]     = acc[0];
    req_access_i[1]     = acc[1];
    ptw_busy_i          = 1'b0;
    ptw_valid_i         = 1'b0;
    access_page_fault_i = 1'b0;
    format_error_i      = '0;
    allow_i             = 1'b0;
    tlb_entry_i         = '0;

    repeat (2) @(negedge clk_i);
    #1 check_reset_outputs("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int k = 0; k < nvec; k++) begin
      @(negedge clk_i);
      flush_i             = vecs[k].fl;
      req_valid_i         = vecs[k].rv;
      ptw_valid_i         = vecs[k].pv;
      access_page_fault_i = vecs[k].apf;
      format_error_i      = vecs[k].fmt;
      allow_i             = vecs[k].alw;
      tlb_entry_i         = vecs[k].tlb;
      ptw_busy_i          = vecs[k].e_en;
      #1;
      cmp($sformatf("v%0d_req_ready", k), 64'(req_ready_o), 64'(vecs[k].e_rdy));
      cmp($sformatf("v%0d_flush_o", k), 64'(flush_o), 64'(vecs[k].fl));
      cmp($sformatf("v%0d_ptw_enable", k), 64'(ptw_enable_o), 64'(vecs[k].e_en));
      cmp($sformatf("v%0d_addr_valid", k), 64'(addr_valid_o), 64'(vecs[k].e_av));
      cmp($sformatf("v%0d_rsp_valid", k), 64'(rsp_valid_o), 64'(vecs[k].e_rsv));
      if (vecs[k].e_en) begin
        cmp($sformatf("v%0d_paddr", k), 64'(paddr_o), 64'(pa[vecs[k].e_own]));
        cmp($sformatf("v%0d_access", k), 64'(access_type_o), 64'(acc[vecs[k].e_own]));
      end
      if (vecs[k].e_chk) begin
        cmp($sformatf("v%0d_rsp_allow", k), 64'(rsp_allow_o), 64'(vecs[k].e_alw));
        cmp($sformatf("v%0d_rsp_fault", k), 64'(rsp_fault_o), 64'(vecs[k].e_flt));
        cmp($sformatf("v%0d_rsp_timeout", k), 64'(rsp_timeout_o), 64'(vecs[k].e_to));
        cmp($sformatf("v%0d_rsp_format", k), 64'(rsp_format_o), 64'(vecs[k].e_fmt));
        cmp($sformatf("v%0d_rsp_tlb", k), rsp_tlb_entry_o, vecs[k].e_tlb);
      end
    end

    // Asynchronous reset in the middle of WAIT; round-robin pointer restarts at 0.
    @(negedge clk_i);
    flush_i = 1'b0; ptw_valid_i = 1'b0; access_page_fault_i = 1'b0;
    format_error_i = '0; allow_i = 1'b0; tlb_entry_i = '0;
    req_valid_i = 2'b01;
    #1 cmp("rst_seq_grant", 64'(req_ready_o), 64'h1);
    @(negedge clk_i);
    req_valid_i = 2'b00;
    @(negedge clk_i);
    #1 cmp("rst_seq_wait_enable", 64'(ptw_enable_o), 64'h1);
    #2 rst_ni = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(negedge clk_i);
    rst_ni      = 1'b1;
    req_valid_i = 2'b11;
    #1 cmp("rr_ptr_after_reset", 64'(req_ready_o), 64'h1);
    @(negedge clk_i);
    req_valid_i = 2'b00;
    @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
